// File: rtl/csr_sched_pkg.sv
// Shared types and default widths for the CSR row scheduler, the mul_sparse
// datapath and the bench.
package csr_sched_pkg;

   localparam int ADDR_W_DEF = 10;
   localparam int ROW_W_DEF  = 10;

   typedef enum logic [2:0] {
      IDLE,
      PTR0,
      PTRN,
      PEND,
      ISSUE,
      DONE
   } sched_state_t;

endpackage

// File: rtl/csr_row_sched.sv
// CSR row scheduler: walks row pointers, issues nonzero addresses under a
// ready/stall handshake. Optional pointer-order check: CSR_SCHED_ERR_CHK_EN.
//
// state | meaning
// IDLE  | waiting for start, all outputs 0
// PTR0  | reading ptr[0]
// PTRN  | reading ptr[row+1]; ptr[0] lands in cur on the first row
// PEND  | end pointer arrives; empty row or go issue
// ISSUE | presenting nz_addr = cur until mac_ready
// DONE  | done pulse (one extra cycle if the last row was empty)
module csr_row_sched
   import csr_sched_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int ROW_W  = ROW_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ROW_W-1:0]  num_rows,
   output logic [ADDR_W-1:0] ptr_addr,
   input  logic [ADDR_W-1:0] ptr_rdata,
   output logic [ADDR_W-1:0] nz_addr,
   output logic              nz_en,
   input  logic              mac_ready,
   output logic [ROW_W-1:0]  row_idx,
   output logic              row_last,
   output logic              row_zero,
   output logic              busy,
   output logic              done,
   output logic              err
);

   sched_state_t      state;
   logic [ROW_W-1:0]  row;
   logic [ROW_W-1:0]  nrows;
   logic [ADDR_W-1:0] cur;
   logic [ADDR_W-1:0] end_p;
   logic              last_row;

   assign last_row = (row == nrows - ROW_W'(1));

`ifndef CSR_SCHED_ERR_CHK_EN
   assign err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         row      <= '0;
         nrows    <= '0;
         cur      <= '0;
         end_p    <= '0;
         ptr_addr <= '0;
         nz_addr  <= '0;
         nz_en    <= 1'b0;
         row_idx  <= '0;
         row_last <= 1'b0;
         row_zero <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
`ifdef CSR_SCHED_ERR_CHK_EN
         err      <= 1'b0;
`endif
      end else begin
         row_zero <= 1'b0;
         done     <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  busy <= 1'b1;
`ifdef CSR_SCHED_ERR_CHK_EN
                  err  <= 1'b0;
`endif
                  if (num_rows != '0) begin
                     nrows    <= num_rows;
                     row      <= '0;
                     row_idx  <= '0;
                     ptr_addr <= '0;
                     state    <= PTR0;
                  end else begin
                     done  <= 1'b1;
                     state <= DONE;
                  end
               end
            end
            PTR0: begin
               ptr_addr <= ADDR_W'(row) + ADDR_W'(1);
               state    <= PTRN;
            end
            PTRN: begin
               if (row == '0)
                  cur <= ptr_rdata;
               row_idx  <= row;
               ptr_addr <= '0;
               state    <= PEND;
            end
            PEND: begin
               end_p <= ptr_rdata;
`ifdef CSR_SCHED_ERR_CHK_EN
               if (ptr_rdata < cur)
                  err <= 1'b1;
`endif
               if (ptr_rdata <= cur) begin
                  // row_idx keeps this row for the row_zero cycle; a last
                  // empty row reaches done through a second DONE cycle
                  row_zero <= 1'b1;
                  if (last_row) begin
                     state <= DONE;
                  end else begin
                     row      <= row + ROW_W'(1);
                     ptr_addr <= ADDR_W'(row) + ADDR_W'(2);
                     state    <= PTRN;
                  end
               end else begin
                  nz_en    <= 1'b1;
                  nz_addr  <= cur;
                  row_last <= (cur + ADDR_W'(1) == ptr_rdata);
                  state    <= ISSUE;
               end
            end
            ISSUE: begin
               if (mac_ready) begin
                  cur <= cur + ADDR_W'(1);
                  if (row_last) begin
                     nz_en    <= 1'b0;
                     nz_addr  <= '0;
                     row_last <= 1'b0;
                     if (last_row) begin
                        done  <= 1'b1;
                        state <= DONE;
                     end else begin
                        row      <= row + ROW_W'(1);
                        row_idx  <= row + ROW_W'(1);
                        ptr_addr <= ADDR_W'(row) + ADDR_W'(2);
                        state    <= PTRN;
                     end
                  end else begin
                     nz_addr  <= cur + ADDR_W'(1);
                     row_last <= (cur + ADDR_W'(2) == end_p);
                  end
               end
            end
            DONE: begin
               if (done) begin
                  busy    <= 1'b0;
                  row_idx <= '0;
                  state   <= IDLE;
               end else begin
                  done <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/csr_row_sched.md
# csr_row_sched

Row scheduler for the row-wise sparse×dense multiplier. Walks a CSR-encoded sparse matrix one row at a time: reads the row-pointer memory, issues nonzero-entry addresses to the MAC datapath under a ready/stall handshake, and flags row boundaries and empty rows. It sits between the testbench or host memories and the `mul_sparse` datapath and replaces ad-hoc address sequencing.

## Interface
- `ADDR_W`, default 10: width of the pointer and nonzero memory addresses, matching the datapath `addrext`.
- `ROW_W`, default 10: width of the row count and row index.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: single-cycle request to begin a matrix; sampled only in IDLE.
- `num_rows` in ROW_W: row count, latched on an accepted `start`.
- `ptr_addr` out ADDR_W: row-pointer memory read address.
- `ptr_rdata` in ADDR_W: row-pointer read data, valid exactly 1 cycle after `ptr_addr`.
- `nz_addr` out ADDR_W: nonzero (col, val) memory address being issued.
- `nz_en` out 1: `nz_addr` is a valid issue this cycle.
- `mac_ready` in 1: datapath accepts the issue when high together with `nz_en`.
- `row_idx` out ROW_W: current row number.
- `row_last` out 1: high with `nz_en` on the final nonzero of the row.
- `row_zero` out 1: one-cycle pulse marking an empty row; drives datapath `zeros`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when the matrix is complete.
- `err` out 1: sticky pointer-order error (see Configuration).

## Operation
- State register, counters `row` and `cur`, and register `end_p`. All outputs are decoded from registers only; there is no combinational path from any input to any output.
- IDLE: all outputs 0.
  - `start` with `num_rows` > 0: latch `num_rows`, set `row` to 0, go to PTR0.
  - `start` with `num_rows` = 0: go to DONE.
- PTR0: `ptr_addr` = 0. Go to PTRN.
- PTRN: `ptr_addr` = `row`+1. On the first row only, `cur` ← `ptr_rdata` (ptr[0]). Go to PEND.
- PEND: `end_p` ← `ptr_rdata`.
  - If `ptr_rdata` ≤ `cur`: pulse `row_zero`, then advance.
  - Otherwise go to ISSUE.
- ISSUE: `nz_en` = 1 and `nz_addr` = `cur`; `row_last` = (`cur`+1 == `end_p`).
  - On `mac_ready`: `cur`++. If this was the last entry, advance.
  - While `mac_ready` = 0: hold `nz_addr` and `nz_en` stable. No entry is skipped or repeated.
- Advance:
  - If `row` == `num_rows`−1: go to DONE.
  - Otherwise `row`++ and go to PTRN. `cur` already holds the new row's start, so the next row needs only one pointer read.
- DONE: pulse `done`, then go to IDLE.
- `start` while busy is ignored.
- `rst` in any state: next state is IDLE; `row`, `cur`, `end_p` and `err` clear to 0; all outputs read 0 from the following cycle. A `start` in the cycle after reset is accepted.
- Address arithmetic is modulo 2^ADDR_W. Pointer values must fit in ADDR_W.

## Timing
- `start` accepted at edge 0. PTR0 is cycle 1, PTRN cycle 2, PEND cycle 3. First `nz_en` is cycle 4.
- Per-row overhead is 2 cycles (PTRN, PEND). A row of n nonzeros with `mac_ready` held high takes n+2 cycles. An empty row takes 2 cycles.
- `done` is asserted 1 cycle after the last accepted issue or the last `row_zero`.
- With `num_rows` = 0, `done` pulses in cycle 1 and no pointer reads occur.
- `row_idx` is stable for the whole of each row, including its `row_zero` cycle.

## Configuration
- `CSR_SCHED_ERR_CHK_EN` defined:
  - In PEND, `ptr_rdata` < `cur` sets `err`. The row is still treated as empty.
  - `err` stays high until the next accepted `start` or `rst`.
- Undefined: `err` is tied 0 and no compare logic is synthesised. Rows with ptr[i+1] < ptr[i] still pulse `row_zero`.

## Structure
- Package `csr_sched_pkg` holds:
  - the state enum (IDLE, PTR0, PTRN, PEND, ISSUE, DONE);
  - the default `ADDR_W` / `ROW_W` localparams, shared with `mul_sparse` and the bench.
- No sub-module. The FSM and counters form a single module; the error check is inline under the macro.

## Test plan
- Basic walk: `num_rows`=3, ptr={0,2,2,5}, `mac_ready`=1 → `nz_addr` 0,1 (`row_last` on 1); `row_zero` with `row_idx`=1; `nz_addr` 2,3,4 (`row_last` on 4); then `done`.
- Stall handling: same matrix with `mac_ready` toggling every cycle → each address held until accepted; the sequence is identical to the basic walk; total cycle count grows by the stall count.
- Zero rows: `num_rows`=0 → `done` in cycle 1, `busy` for 1 cycle, `ptr_addr` stays 0.
- Reset mid-row: `rst` during ISSUE at `nz_addr`=3 → all outputs 0 on the next cycle; a following `start` re-walks from ptr[0].
- Pointer error (macro on): ptr={0,3,1} → row0 issues 0,1,2; row1 pulses `row_zero` and sets `err`=1; `err` clears on the next `start`.
- Start while busy: a second `start` pulsed in ISSUE is ignored, with no change to `row_idx` or `nz_addr`.
